cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result writeback arbiter that shares the single common-data-bus (CDB) result port between the ALU, the memory unit and the branch unit. Each source pushes tagged results into a private 2-entry FIFO; a round-robin arbiter pops at most one result per cycle onto the registered CDB outputs. Those outputs drive the ROB result inputs (`alu_num`/`alu_value` path) and the reservation-station wakeup. A flush input discards all in-flight results on a pipeline redirect.

## Interface
Parameters:
- `TAG_W`, 3: ROB tag width. Tag 0 means "no result"; live entries are 1..7.
- `DATA_W`, 32: result value width.
- `DEPTH`, 2: per-source FIFO depth. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all buffered results.
- `alu_valid` / `mem_valid` / `br_valid`  in  1 each  source offers a result this cycle.
- `alu_num` / `mem_num` / `br_num`  in  `TAG_W` each  ROB tag of the offered result.
- `alu_value` / `mem_value` / `br_value`  in  `DATA_W` each  result value (branch unit: 0 = not taken, nonzero = taken).
- `alu_ready` / `mem_ready` / `br_ready`  out  1 each  the source FIFO can accept a result.
- `cdb_num`  out  `TAG_W`  broadcast tag; 0 = idle.
- `cdb_value`  out  `DATA_W`  broadcast value; 0 when idle.
- `cdb_src`  out  2  granted source: 0 alu, 1 mem, 2 br, 3 idle.
- `pending`  out  1  at least one FIFO is non-empty.

## Operation
- Acceptance: a result is accepted when `x_valid && x_ready` at posedge, and `x_num != 0`, and neither `flush` nor `rst` is high.
  - A valid offer with tag 0 is dropped silently and never enqueued.
- `x_ready = (count_x < DEPTH)`, taken from registered count only. No same-cycle pop credit, so there is no combinational path from grant to ready.
- Each FIFO:
  - Circular buffer with read/write pointers `log2(DEPTH)` bits wide, wrapping modulo `DEPTH`.
  - `count` is `log2(DEPTH)+1` bits.
  - A simultaneous push and pop leaves `count` unchanged.
- Arbitration:
  - Candidates are the FIFOs that are non-empty at the start of the cycle. Results accepted this cycle are not candidates.
  - Priority pointer `rr` takes values 0..2; the search order is `rr, rr+1, rr+2` mod 3.
  - The first non-empty source wins. Its head is popped and registered onto `cdb_num`/`cdb_value`/`cdb_src`.
  - After a grant to source s, `rr <= (s+1) mod 3`. With no grant, `rr` is unchanged.
- Idle cycle (no candidates): `cdb_num <= 0`, `cdb_value <= 0`, `cdb_src <= 3`.
- Flush:
  - Clears all counts and pointers, registers CDB idle, sets `rr <= 0`.
  - A result offered in the same cycle is dropped.
  - Flush takes priority over push and pop.
- `pending` is combinational OR of the three `count != 0`.
- Values are passed through unmodified. The block performs no arithmetic beyond pointer and count increment, decrement and wrap.

## Timing
- Reset values: all FIFOs empty; `rr = 0`; `cdb_num = 0`; `cdb_value = 0`; `cdb_src = 3`; all `x_ready = 1`; `pending = 0`.
- Latency: a result accepted at edge N appears on the CDB after edge N+1 at the earliest. It is held for exactly one cycle.
- Throughput: one CDB broadcast per cycle. A single source streaming back-to-back sustains 1 result per cycle with `DEPTH >= 2`.
- FIFO full:
  - `x_ready` drops in the cycle after the accepting edge that fills the FIFO.
  - It rises in the cycle after the edge that pops an entry.
  - A source must hold `valid`, `num` and `value` until it sees ready.
- Starvation bound: a non-empty source is granted within 3 cycles.
- Reset or flush mid-burst: the following cycle shows `cdb_num = 0` and all `x_ready = 1`. No stale tag is ever broadcast.

## Test plan
- Reset, then `alu` offers tag 3, value 0x10 for one cycle -> `alu_ready = 1`; the cycle after the edge shows `cdb_num = 3`, `cdb_value = 0x10`, `cdb_src = 0`; the next cycle shows `cdb_num = 0`, `cdb_src = 3`.
- All three sources offer every cycle with tags alu 1/4, mem 2/5, br 3/6 -> CDB sequence 1, 2, 3, 4, 5, 6 with `cdb_src` 0, 1, 2, 0, 1, 2. No tag is lost or duplicated.
- `mem` offers tags 1, 2, 3 while `alu` floods -> `mem_ready` drops after 2 accepts, tag 3 is held and accepted later, and every `mem` result is granted within 3 cycles.
- `br` offers tag 5 value 0, then `alu` offers tag 0 value 0xFF -> CDB shows tag 5 value 0; the tag-0 offer never appears and `pending` returns to 0.
- Fill `alu` (tags 1, 2) and `mem` (tag 3), then assert `flush` together with a `br` offer of tag 7 -> next cycle `cdb_num = 0`, `pending = 0`, all ready = 1, and tag 7 never broadcast.
- Reset asserted while two FIFOs are full -> all outputs return to reset values the following cycle; the next offer of tag 4 is broadcast with `cdb_src` reflecting `rr = 0` ordering.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB result writeback arbiter with per-source result FIFOs

module cdb_fifo #(
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push_valid,
   input  logic [TAG_W-1:0]  push_num,
   input  logic [DATA_W-1:0] push_value,
   input  logic              pop,
   output logic              ready,
   output logic              nonempty,
   output logic [TAG_W-1:0]  head_num,
   output logic [DATA_W-1:0] head_value
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [TAG_W-1:0]  num_mem   [DEPTH];
   logic [DATA_W-1:0] value_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop_ok;

   // Tag 0 means "no result", so such offers are never stored.
   assign ready      = (count < FULL);
   assign nonempty   = (count != '0);
   assign push       = push_valid && ready && (push_num != '0) && !flush && !rst;
   assign pop_ok     = pop && nonempty && !flush;
   assign head_num   = num_mem[rd_ptr];
   assign head_value = value_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         num_mem[wr_ptr]   <= push_num;
         value_mem[wr_ptr] <= push_value;
      end
   end
endmodule

module cdb_arbiter #(
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alu_valid,
   input  logic [TAG_W-1:0]  alu_num,
   input  logic [DATA_W-1:0] alu_value,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [TAG_W-1:0]  mem_num,
   input  logic [DATA_W-1:0] mem_value,
   output logic              mem_ready,
   input  logic              br_valid,
   input  logic [TAG_W-1:0]  br_num,
   input  logic [DATA_W-1:0] br_value,
   output logic              br_ready,
   output logic [TAG_W-1:0]  cdb_num,
   output logic [DATA_W-1:0] cdb_value,
   output logic [1:0]        cdb_src,
   output logic              pending
);
   logic [2:0]        nonempty;
   logic [2:0]        pop;
   logic [TAG_W-1:0]  head_num   [3];
   logic [DATA_W-1:0] head_value [3];
   logic [1:0]        rr;
   logic [1:0]        grant;
   logic [1:0]        next_rr;
   logic              grant_valid;
   logic [TAG_W-1:0]  grant_num;
   logic [DATA_W-1:0] grant_value;

   cdb_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_alu_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(alu_valid), .push_num(alu_num), .push_value(alu_value),
      .pop(pop[0]), .ready(alu_ready), .nonempty(nonempty[0]),
      .head_num(head_num[0]), .head_value(head_value[0])
   );

   cdb_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(mem_valid), .push_num(mem_num), .push_value(mem_value),
      .pop(pop[1]), .ready(mem_ready), .nonempty(nonempty[1]),
      .head_num(head_num[1]), .head_value(head_value[1])
   );

   cdb_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_br_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(br_valid), .push_num(br_num), .push_value(br_value),
      .pop(pop[2]), .ready(br_ready), .nonempty(nonempty[2]),
      .head_num(head_num[2]), .head_value(head_value[2])
   );

   assign pending     = |nonempty;
   assign grant_valid = |nonempty;

   // Round-robin search starting at rr; only entries present before this edge compete.
   always_comb begin
      grant = 2'd3;
      case (rr)
         2'd1: begin
            if (nonempty[1])      grant = 2'd1;
            else if (nonempty[2]) grant = 2'd2;
            else if (nonempty[0]) grant = 2'd0;
         end
         2'd2: begin
            if (nonempty[2])      grant = 2'd2;
            else if (nonempty[0]) grant = 2'd0;
            else if (nonempty[1]) grant = 2'd1;
         end
         default: begin
            if (nonempty[0])      grant = 2'd0;
            else if (nonempty[1]) grant = 2'd1;
            else if (nonempty[2]) grant = 2'd2;
         end
      endcase
   end

   always_comb begin
      grant_num   = '0;
      grant_value = '0;
      next_rr     = rr;
      case (grant)
         2'd0: begin grant_num = head_num[0]; grant_value = head_value[0]; next_rr = 2'd1; end
         2'd1: begin grant_num = head_num[1]; grant_value = head_value[1]; next_rr = 2'd2; end
         2'd2: begin grant_num = head_num[2]; grant_value = head_value[2]; next_rr = 2'd0; end
         default: ;
      endcase
   end

   assign pop = {grant == 2'd2, grant == 2'd1, grant == 2'd0} & {3{grant_valid && !flush}};

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cdb_num   <= '0;
         cdb_value <= '0;
         cdb_src   <= 2'd3;
         rr        <= 2'd0;
      end else if (grant_valid) begin
         cdb_num   <= grant_num;
         cdb_value <= grant_value;
         cdb_src   <= grant;
         rr        <= next_rr;
      end else begin
         cdb_num   <= '0;
         cdb_value <= '0;
         cdb_src   <= 2'd3;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter

module tb_cdb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        alu_valid = 1'b0, mem_valid = 1'b0, br_valid = 1'b0;
   logic [2:0]  alu_num = '0, mem_num = '0, br_num = '0;
   logic [31:0] alu_value = '0, mem_value = '0, br_value = '0;
   logic        alu_ready, mem_ready, br_ready;
   logic [2:0]  cdb_num;
   logic [31:0] cdb_value;
   logic [1:0]  cdb_src;
   logic        pending;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [2:0]  num;
      logic [31:0] val;
   } ent_t;

   ent_t alu_q[$];
   ent_t mem_q[$];
   ent_t br_q[$];
   int   obs_num[$];
   int   obs_src[$];
   int   acc_cyc[8];
   int   lat_max[4];
   int   mem_acc;
   int   mem_block_at;

   cdb_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alu_valid(alu_valid), .alu_num(alu_num), .alu_value(alu_value), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_num(mem_num), .mem_value(mem_value), .mem_ready(mem_ready),
      .br_valid(br_valid), .br_num(br_num), .br_value(br_value), .br_ready(br_ready),
      .cdb_num(cdb_num), .cdb_value(cdb_value), .cdb_src(cdb_src), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_num = '0; alu_value = '0;
      mem_valid = 1'b0; mem_num = '0; mem_value = '0;
      br_valid  = 1'b0; br_num  = '0; br_value  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      flush = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      obs_num.delete();
      obs_src.delete();
      for (int i = 0; i < 4; i++) lat_max[i] = 0;
      for (int i = 0; i < 8; i++) acc_cyc[i] = 0;
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_cdb_num"}, cdb_num, 0);
      check({pfx, "_cdb_value"}, cdb_value, 0);
      check({pfx, "_cdb_src"}, cdb_src, 3);
      check({pfx, "_alu_ready"}, alu_ready, 1);
      check({pfx, "_mem_ready"}, mem_ready, 1);
      check({pfx, "_br_ready"}, br_ready, 1);
      check({pfx, "_pending"}, pending, 0);
   endtask

   // Sources follow valid/ready: each holds its queue head until an edge with ready high.
   task automatic stream(input int cycles);
      logic acc_a, acc_m, acc_b;
      int   lat;
      mem_acc = 0;
      mem_block_at = -1;
      for (int c = 0; c < cycles; c++) begin
         idle_inputs();
         if (alu_q.size() > 0) begin alu_valid = 1'b1; alu_num = alu_q[0].num; alu_value = alu_q[0].val; end
         if (mem_q.size() > 0) begin mem_valid = 1'b1; mem_num = mem_q[0].num; mem_value = mem_q[0].val; end
         if (br_q.size() > 0)  begin br_valid  = 1'b1; br_num  = br_q[0].num;  br_value  = br_q[0].val;  end
         acc_a = alu_valid && alu_ready;
         acc_m = mem_valid && mem_ready;
         acc_b = br_valid && br_ready;
         if (mem_block_at < 0 && mem_valid && !mem_ready) mem_block_at = mem_acc;
         tick();
         if (acc_a) begin acc_cyc[alu_num] = c + 1; void'(alu_q.pop_front()); end
         if (acc_m) begin acc_cyc[mem_num] = c + 1; void'(mem_q.pop_front()); mem_acc++; end
         if (acc_b) begin acc_cyc[br_num]  = c + 1; void'(br_q.pop_front()); end
         if (cdb_num != 0) begin
            obs_num.push_back(int'(cdb_num));
            obs_src.push_back(int'(cdb_src));
            lat = c + 1 - acc_cyc[cdb_num];
            if (lat > lat_max[cdb_src]) lat_max[cdb_src] = lat;
         end
      end
      idle_inputs();
   endtask

   initial begin
      int exp3_num[6] = '{1, 2, 3, 4, 5, 6};
      int exp3_src[6] = '{0, 1, 2, 0, 1, 2};
      int exp4_num[7] = '{4, 1, 5, 2, 6, 3, 7};
      int exp4_src[7] = '{0, 1, 0, 1, 0, 1, 0};
      logic seen7, seen_any;

      // reset state
      do_reset();
      check_reset_state("rst");

      // single alu result: one-cycle latency, held for exactly one cycle
      alu_valid = 1'b1; alu_num = 3'd3; alu_value = 32'h10;
      check("t1_alu_ready", alu_ready, 1);
      tick();
      idle_inputs();
      check("t1_pending", pending, 1);
      check("t1_no_bypass", cdb_num, 0);
      tick();
      check("t1_num", cdb_num, 3);
      check("t1_value", cdb_value, 32'h10);
      check("t1_src", cdb_src, 0);
      tick();
      check("t1_idle_num", cdb_num, 0);
      check("t1_idle_src", cdb_src, 3);
      check("t1_idle_pending", pending, 0);

      // all three sources offering every cycle
      do_reset();
      alu_q = '{'{3'd1, 32'hA1}, '{3'd4, 32'hA4}};
      mem_q = '{'{3'd2, 32'hB2}, '{3'd5, 32'hB5}};
      br_q  = '{'{3'd3, 32'hC3}, '{3'd6, 32'hC6}};
      stream(10);
      check("t3_count", obs_num.size(), 6);
      for (int i = 0; i < 6 && i < obs_num.size(); i++) begin
         check($sformatf("t3_num%0d", i), obs_num[i], exp3_num[i]);
         check($sformatf("t3_src%0d", i), obs_src[i], exp3_src[i]);
      end
      check("t3_drained", pending, 0);

      // mem backs up behind a flooding alu
      do_reset();
      alu_q = '{'{3'd4, 32'h4}, '{3'd5, 32'h5}, '{3'd6, 32'h6}, '{3'd7, 32'h7}};
      mem_q = '{'{3'd1, 32'h1}, '{3'd2, 32'h2}, '{3'd3, 32'h3}};
      br_q.delete();
      stream(12);
      check("t4_mem_block_after", mem_block_at, 2);
      check("t4_count", obs_num.size(), 7);
      for (int i = 0; i < 7 && i < obs_num.size(); i++) begin
         check($sformatf("t4_num%0d", i), obs_num[i], exp4_num[i]);
         check($sformatf("t4_src%0d", i), obs_src[i], exp4_src[i]);
      end
      check("t4_mem_max_wait", lat_max[1], 3);

      // branch not-taken value 0 passes through; tag-0 offer is dropped
      do_reset();
      br_valid = 1'b1; br_num = 3'd5; br_value = 32'h0;
      tick();
      idle_inputs();
      alu_valid = 1'b1; alu_num = 3'd0; alu_value = 32'hFF;
      tick();
      idle_inputs();
      check("t5_num", cdb_num, 5);
      check("t5_value", cdb_value, 0);
      check("t5_src", cdb_src, 2);
      check("t5_pending", pending, 0);
      tick();
      check("t5_tag0_num", cdb_num, 0);
      check("t5_tag0_value", cdb_value, 0);

      // flush with buffered results and a same-cycle br offer
      do_reset();
      alu_valid = 1'b1; alu_num = 3'd1; alu_value = 32'h11;
      mem_valid = 1'b1; mem_num = 3'd3; mem_value = 32'h33;
      tick();
      idle_inputs();
      alu_valid = 1'b1; alu_num = 3'd2; alu_value = 32'h22;
      tick();
      idle_inputs();
      check("t6_pre_num", cdb_num, 1);
      check("t6_pre_pending", pending, 1);
      flush = 1'b1;
      br_valid = 1'b1; br_num = 3'd7; br_value = 32'h77;
      tick();
      flush = 1'b0;
      idle_inputs();
      check_reset_state("t6");
      seen7 = 1'b0;
      seen_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cdb_num == 3'd7) seen7 = 1'b1;
         if (cdb_num != 3'd0) seen_any = 1'b1;
      end
      check("t6_tag7_seen", seen7, 0);
      check("t6_stale_seen", seen_any, 0);

      // reset while mem and br are full; rr restarts at alu
      do_reset();
      alu_valid = 1'b1; alu_num = 3'd1; alu_value = 32'h1;
      mem_valid = 1'b1; mem_num = 3'd2; mem_value = 32'h2;
      br_valid  = 1'b1; br_num  = 3'd3; br_value  = 32'h3;
      tick();
      alu_num = 3'd5; mem_num = 3'd6; br_num = 3'd7;
      tick();
      idle_inputs();
      check("t7_mem_full", mem_ready, 0);
      check("t7_br_full", br_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("t7");
      alu_valid = 1'b1; alu_num = 3'd4; alu_value = 32'h44;
      mem_valid = 1'b1; mem_num = 3'd5; mem_value = 32'h55;
      tick();
      idle_inputs();
      tick();
      check("t7_first_num", cdb_num, 4);
      check("t7_first_src", cdb_src, 0);
      check("t7_first_value", cdb_value, 32'h44);
      tick();
      check("t7_second_num", cdb_num, 5);
      check("t7_second_src", cdb_src, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
